// File: rtl/deck_list_reader_pkg.sv
// Shared definitions for the deck list reader: card node field layout, null address,
// suit encodings and walk FSM states.
package deck_list_reader_pkg;

   localparam int unsigned ALLOC_BIT  = 31;
   localparam int unsigned VALUE_MSB  = 15;
   localparam int unsigned VALUE_LSB  = 12;
   localparam int unsigned SUIT_MSB   = 11;
   localparam int unsigned SUIT_LSB   = 10;
   localparam int unsigned NEXT_MSB   = 9;
   localparam int unsigned NEXT_LSB   = 0;

   localparam int unsigned NULL_ADDR  = 0;
   localparam int unsigned CARD_CNT_W = 6;

   typedef enum logic [1:0] {
      SuitClubs    = 2'd0,
      SuitDiamonds = 2'd1,
      SuitHearts   = 2'd2,
      SuitSpades   = 2'd3
   } suit_e;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StFetch = 3'd1,
      StWait  = 3'd2,
      StCheck = 3'd3,
      StEmit  = 3'd4,
      StDone  = 3'd5
   } state_e;

endpackage

// File: rtl/deck_list_reader_if.sv
// Start/card-stream handshake and RAM-side port bundle of the deck list reader.
// The master modport is the reader; the slave modport is its controller/consumer/RAM side.
interface deck_list_reader_if
   import deck_list_reader_pkg::*;
#(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 32
);

   logic                  enable;
   logic [ADDR_W-1:0]     head_addr;
   logic                  card_valid;
   logic                  card_ready;
   logic [3:0]            card_value;
   logic [1:0]            card_suit;
   logic                  finished_reading;
   logic [CARD_CNT_W-1:0] card_count;
   logic                  list_error;
   logic [ADDR_W-1:0]     ram_address;
   logic                  ram_clock;
   logic [DATA_W-1:0]     ram_data;
   logic                  ram_wren;
   logic [DATA_W-1:0]     ram_q;

   modport master (
      input  enable, head_addr, card_ready, ram_q,
      output card_valid, card_value, card_suit, finished_reading, card_count, list_error,
             ram_address, ram_clock, ram_data, ram_wren
   );

   modport slave (
      output enable, head_addr, card_ready, ram_q,
      input  card_valid, card_value, card_suit, finished_reading, card_count, list_error,
             ram_address, ram_clock, ram_data, ram_wren
   );

endinterface

// File: rtl/deck_list_reader_card_node_decode.sv
// Combinational split of a 32-bit card node word into alloc flag, value, suit and next pointer.
module deck_list_reader_card_node_decode
   import deck_list_reader_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic [31:0]       i_word,
   output logic              o_alloc,
   output logic [3:0]        o_value,
   output logic [1:0]        o_suit,
   output logic [ADDR_W-1:0] o_next
);

   assign o_alloc = i_word[ALLOC_BIT];
   assign o_value = i_word[VALUE_MSB:VALUE_LSB];
   assign o_suit  = i_word[SUIT_MSB:SUIT_LSB];
   assign o_next  = i_word[NEXT_LSB +: ADDR_W];

   // Reserved bits between the alloc flag and the value field.
   logic w_unused_bits;
   assign w_unused_bits = ^i_word[30:16];

endmodule

// File: rtl/deck_list_reader.sv
// Walks one linked card list in the card RAM and streams (value, suit) over valid/ready.
// Optional macro DECK_LIST_READER_ALLOC_CHECK_EN: stop with list_error on an unallocated node.
module deck_list_reader
   import deck_list_reader_pkg::*;
#(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MAX_CARDS = 52,
   parameter int unsigned RAM_LAT   = 1
) (
   input  logic               i_clock,
   input  logic               i_resetn,
   deck_list_reader_if.master io_bus
);

   localparam int unsigned        WAIT_W  = (RAM_LAT > 1) ? $clog2(RAM_LAT + 1) : 1;
   localparam logic [WAIT_W-1:0]  LAT_CNT = WAIT_W'(RAM_LAT);
   localparam logic [CARD_CNT_W-1:0] MAX_CNT = CARD_CNT_W'(MAX_CARDS);
   localparam logic [ADDR_W-1:0]  NULL_A  = ADDR_W'(NULL_ADDR);

   state_e                r_state;
   logic [ADDR_W-1:0]     r_cur_addr;
   logic [ADDR_W-1:0]     r_next_addr;
   logic [ADDR_W-1:0]     r_ram_address;
   logic [WAIT_W-1:0]     r_wait_cnt;
   logic [CARD_CNT_W-1:0] r_count;
   logic [CARD_CNT_W-1:0] r_card_count;
   logic                  r_card_valid;
   logic [3:0]            r_card_value;
   logic [1:0]            r_card_suit;
   logic                  r_finished;
   logic                  r_list_error;

   logic                  w_alloc;
   logic [3:0]            w_value;
   logic [1:0]            w_suit;
   logic [ADDR_W-1:0]     w_next;
   logic                  w_node_ok;
   logic [CARD_CNT_W-1:0] w_count_inc;

   deck_list_reader_card_node_decode #(
      .ADDR_W (ADDR_W)
   ) u_node_decode (
      .i_word  (io_bus.ram_q[31:0]),
      .o_alloc (w_alloc),
      .o_value (w_value),
      .o_suit  (w_suit),
      .o_next  (w_next)
   );

`ifdef DECK_LIST_READER_ALLOC_CHECK_EN
   assign w_node_ok = w_alloc;
`else
   // Bit 31 is ignored: every reached node is emitted.
   assign w_node_ok = 1'b1;
   logic w_unused_alloc;
   assign w_unused_alloc = w_alloc;
`endif

   assign w_count_inc = r_count + CARD_CNT_W'(1);

   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state       <= StIdle;
         r_cur_addr    <= '0;
         r_next_addr   <= '0;
         r_ram_address <= '0;
         r_wait_cnt    <= '0;
         r_count       <= '0;
         r_card_count  <= '0;
         r_card_valid  <= 1'b0;
         r_card_value  <= '0;
         r_card_suit   <= '0;
         r_finished    <= 1'b0;
         r_list_error  <= 1'b0;
      end else begin
         r_finished <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (io_bus.enable) begin
                  r_cur_addr   <= io_bus.head_addr;
                  r_count      <= '0;
                  r_list_error <= 1'b0;
                  r_state      <= (io_bus.head_addr == NULL_A) ? StDone : StFetch;
               end
            end
            StFetch: begin
               r_ram_address <= r_cur_addr;
               r_wait_cnt    <= LAT_CNT;
               r_state       <= StWait;
            end
            StWait: begin
               r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
               if (r_wait_cnt <= WAIT_W'(1)) begin
                  r_state <= StCheck;
               end
            end
            StCheck: begin
               if (!w_node_ok) begin
                  r_list_error <= 1'b1;
                  r_state      <= StDone;
               end else begin
                  r_card_value <= w_value;
                  r_card_suit  <= w_suit;
                  r_next_addr  <= w_next;
                  r_card_valid <= 1'b1;
                  r_state      <= StEmit;
               end
            end
            StEmit: begin
               if (io_bus.card_ready) begin
                  r_card_valid <= 1'b0;
                  r_count      <= w_count_inc;
                  r_cur_addr   <= r_next_addr;
                  if (r_next_addr == NULL_A || w_count_inc == MAX_CNT) begin
                     // Loop guard tripped on a list that still points onward.
                     if (r_next_addr != NULL_A) begin
                        r_list_error <= 1'b1;
                     end
                     r_state <= StDone;
                  end else begin
                     r_state <= StFetch;
                  end
               end
            end
            StDone: begin
               r_finished   <= 1'b1;
               r_card_count <= r_count;
               r_state      <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign io_bus.card_valid       = r_card_valid;
   assign io_bus.card_value       = r_card_value;
   assign io_bus.card_suit        = r_card_suit;
   assign io_bus.finished_reading = r_finished;
   assign io_bus.card_count       = r_card_count;
   assign io_bus.list_error       = r_list_error;
   assign io_bus.ram_address      = r_ram_address;
   assign io_bus.ram_clock        = i_clock;
   assign io_bus.ram_data         = {DATA_W{1'b0}};
   assign io_bus.ram_wren         = 1'b0;

endmodule

// File: tb/tb_deck_list_reader.sv
// Scoreboard bench for deck_list_reader: a reference list walk queues expected cards,
// a negedge monitor pops them on every accepted handshake.
module tb_deck_list_reader;

`ifdef DECK_LIST_READER_ALLOC_CHECK_EN
   localparam bit ALLOC_CHK = 1'b1;
`else
   localparam bit ALLOC_CHK = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic [31:0] mem [0:1023];
   logic [5:0]  q_exp [$];

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   en_cyc = 0;
   int   fin_cyc = 0;
   bit   fin_seen = 1'b0;
   logic [5:0] fin_cnt = '0;
   logic fin_err = 1'b0;
   int   exp_cnt = 0;
   bit   exp_err = 1'b0;

   deck_list_reader_if #(.ADDR_W(10), .DATA_W(32)) bus ();

   deck_list_reader #(
      .ADDR_W    (10),
      .DATA_W    (32),
      .MAX_CARDS (52),
      .RAM_LAT   (1)
   ) dut (
      .i_clock  (clk),
      .i_resetn (rst_n),
      .io_bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // One-cycle synchronous-read RAM.
   always @(posedge clk) bus.ram_q <= mem[bus.ram_address];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] node(input bit a, input int v, input int s, input int nx);
      return {a, 15'd0, 4'(v), 2'(s), 10'(nx)};
   endfunction

   function automatic logic [31:0] out_vec();
      return {7'd0, bus.card_valid, bus.card_value, bus.card_suit, bus.finished_reading,
              bus.card_count, bus.list_error, bus.ram_address};
   endfunction

   // Reference walk of the bench's own RAM image.
   task automatic model_walk(input logic [9:0] head);
      logic [9:0]  a;
      logic [31:0] w;
      int          n;
      a = head;
      n = 0;
      exp_err = 1'b0;
      while (a != 10'd0) begin
         w = mem[a];
         if (ALLOC_CHK && !w[31]) begin
            exp_err = 1'b1;
            break;
         end
         q_exp.push_back({w[15:12], w[11:10]});
         n++;
         if (n == 52) begin
            if (w[9:0] != 10'd0) exp_err = 1'b1;
            break;
         end
         a = w[9:0];
      end
      exp_cnt = n;
   endtask

   task automatic walk_start(input logic [9:0] head);
      model_walk(head);
      fin_seen = 1'b0;
      @(posedge clk);
      #1;
      en_cyc = cyc;
      bus.head_addr = head;
      bus.enable = 1'b1;
      @(posedge clk);
      #1;
      bus.enable = 1'b0;
   endtask

   task automatic walk_end(input int lat);
      int t;
      t = 0;
      while (!fin_seen && t < 2000) begin
         @(posedge clk);
         t++;
      end
      if (!fin_seen) begin
         check_val("timeout", 32'(fin_seen), 32'(1));
      end else begin
         check_val("card_count", 32'(fin_cnt), 32'(exp_cnt));
         check_val("list_error", 32'(fin_err), 32'(exp_err));
         check_val("leftover", 32'(q_exp.size()), 32'(0));
         if (lat >= 0) check_val("latency", 32'(fin_cyc - en_cyc), 32'(lat));
         @(negedge clk);
         #1;
         check_val("fin_pulse", 32'(bus.finished_reading), 32'(0));
      end
      q_exp.delete();
   endtask

   // Monitor: acceptance happens on the next posedge whenever valid & ready here.
   initial begin
      logic [5:0] e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.card_valid && bus.card_ready) begin
               if (q_exp.size() == 0) begin
                  check_val("extra_card", 32'({bus.card_value, bus.card_suit}), 32'(0));
               end else begin
                  e = q_exp.pop_front();
                  check_val("card", 32'({bus.card_value, bus.card_suit}), 32'(e));
               end
            end
            if (bus.finished_reading) begin
               fin_seen = 1'b1;
               fin_cyc  = cyc;
               fin_cnt  = bus.card_count;
               fin_err  = bus.list_error;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got still running, expected finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t;
      bus.enable     = 1'b0;
      bus.head_addr  = '0;
      bus.card_ready = 1'b1;
      rst_n          = 1'b1;
      for (int i = 0; i < 1024; i++) mem[i] = '0;

      #3 rst_n = 1'b0;
      #1 check_val("reset_async", out_vec(), 32'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("reset_idle", out_vec(), 32'(0));
      check_val("ram_wren", 32'(bus.ram_wren), 32'(0));
      check_val("ram_data", bus.ram_data, 32'(0));
      check_val("ram_clock", 32'(bus.ram_clock), 32'(clk));

      // Three-node list, ready held high.
      mem[10'h020] = node(1'b1, 5, 2, 10'h040);
      mem[10'h040] = node(1'b1, 13, 0, 10'h060);
      mem[10'h060] = node(1'b1, 1, 3, 10'h000);
      walk_start(10'h020);
      walk_end(14);

      // Backpressure on the first card.
      bus.card_ready = 1'b0;
      walk_start(10'h020);
      t = 0;
      while (!bus.card_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      check_val("bp_valid", 32'(bus.card_valid), 32'(1));
      repeat (10) begin
         @(negedge clk);
         check_val("bp_hold", 32'({bus.card_valid, bus.card_value, bus.card_suit}),
                   32'({1'b1, 4'd5, 2'd2}));
      end
      @(posedge clk);
      #1 bus.card_ready = 1'b1;
      walk_end(-1);

      // Self-loop: loop guard stops after 52 cards.
      mem[10'h200] = node(1'b1, 7, 1, 10'h200);
      walk_start(10'h200);
      walk_end(52 * 4 + 2);

      // Empty list; also shows list_error cleared by the new enable.
      walk_start(10'h000);
      walk_end(2);

`ifdef DECK_LIST_READER_ALLOC_CHECK_EN
      mem[10'h300] = node(1'b1, 9, 1, 10'h320);
      mem[10'h320] = node(1'b0, 4, 2, 10'h340);
      mem[10'h340] = node(1'b1, 2, 3, 10'h000);
      walk_start(10'h300);
      walk_end(-1);
`endif

      // Reset asserted while the second card is on offer.
      walk_start(10'h020);
      t = 0;
      do begin
         @(negedge clk);
         #1;
         t++;
      end while (!(bus.card_valid && bus.card_value == 4'd13) && t < 100);
      check_val("abort_reached", 32'({bus.card_valid, bus.card_value}), 32'({1'b1, 4'd13}));
      rst_n = 1'b0;
      #1 check_val("abort_async", out_vec(), 32'(0));
      q_exp.delete();
      fin_seen = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      check_val("abort_no_fin", 32'(fin_seen), 32'(0));
      walk_start(10'h020);
      walk_end(14);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
